// File: rtl/sysid_read_arbiter.sv
// rtl/sysid_read_arbiter.sv - round-robin read arbiter for the shared system-ID slave
module sysid_read_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1326413930,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_read,
    input  logic [NUM_REQ-1:0]   req_address,
    output logic [NUM_REQ-1:0]   req_waitrequest,
    output logic [NUM_REQ-1:0]   req_readdatavalid,
    output logic [31:0]          req_readdata,
    output logic                 sid_address,
    input  logic [31:0]          sid_readdata,
    output logic                 id_mismatch,
    output logic [CNT_WIDTH-1:0] read_count
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    logic [0:0]         state;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      winner;
    logic [GW-1:0]      idx_w;
    logic               found;
    int                 idx;
    logic               value_bad;
    logic [NUM_REQ-1:0] grant_onehot;

    // Search starts just past the previous winner so every core gets a turn.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(last_grant) + k) % NUM_REQ;
            idx_w = GW'(idx);
            if (!found && req_read[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = (grant == GW'(i));
        end
    end

    always_comb begin
        req_waitrequest = '1;
        if (state == READ) begin
            req_waitrequest = ~grant_onehot;
        end
    end

    assign value_bad = sid_address ? (sid_readdata != EXPECTED_TS)
                                   : (sid_readdata != EXPECTED_ID);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            grant             <= '0;
            last_grant        <= LAST_INIT;
            sid_address       <= 1'b0;
            req_readdata      <= '0;
            req_readdatavalid <= '0;
            id_mismatch       <= 1'b0;
            read_count        <= '0;
        end else begin
            req_readdatavalid <= '0;
            case (state)
                IDLE: begin
                    if (|req_read) begin
                        grant       <= winner;
                        last_grant  <= winner;
                        sid_address <= req_address[winner];
                        state       <= READ;
                    end
                end
                READ: begin
                    state <= IDLE;
                    // A core dropping read before acceptance gets nothing back.
                    if (req_read[grant]) begin
                        req_readdata      <= sid_readdata;
                        req_readdatavalid <= grant_onehot;
                        if (value_bad) begin
                            id_mismatch <= 1'b1;
                        end
                        if (read_count != {CNT_WIDTH{1'b1}}) begin
                            read_count <= read_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// tb/tb_sysid_read_arbiter.sv - scoreboard bench for sysid_read_arbiter
module tb_sysid_read_arbiter;

    localparam logic [31:0] TS = 32'd1326413930;
    localparam logic [31:0] ID = 32'd0;

    typedef struct {
        int          core;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_read;
    logic [3:0]  req_address;
    logic [3:0]  wr, rdv, wr4, rdv4;
    logic [31:0] rdata, rdata4, sid_rd, sid_rd4;
    logic        sid_addr, sid_addr4, mism, mism4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic [31:0] id_val;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_cnt = 0;

    always #5 clock = ~clock;

    assign sid_rd  = sid_addr  ? TS : id_val;
    assign sid_rd4 = sid_addr4 ? TS : id_val;

    sysid_read_arbiter #(.NUM_REQ(4), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .req_read(req_read), .req_address(req_address),
        .req_waitrequest(wr), .req_readdatavalid(rdv), .req_readdata(rdata),
        .sid_address(sid_addr), .sid_readdata(sid_rd), .id_mismatch(mism), .read_count(cnt)
    );

    sysid_read_arbiter #(.NUM_REQ(4), .CNT_WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .req_read(req_read), .req_address(req_address),
        .req_waitrequest(wr4), .req_readdatavalid(rdv4), .req_readdata(rdata4),
        .sid_address(sid_addr4), .sid_readdata(sid_rd4), .id_mismatch(mism4), .read_count(cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int core, input logic [31:0] d);
        exp_t e;
        e.core = core;
        e.data = d;
        sb.push_back(e);
        model_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_read = '0;
        req_address = '0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        model_cnt = 0;
    endtask

    task automatic serve(input int core, input logic a, input logic [31:0] d);
        int n;
        req_address[core] = a;
        req_read[core] = 1'b1;
        push(core, d);
        n = 0;
        do begin
            tick();
            n++;
        end while (wr[core] && n < 12);
        if (wr[core]) check("serve_timeout", {31'd0, wr[core]}, 32'd0);
        tick();
        req_read[core] = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && |rdv) begin
            if (sb.size() == 0) begin
                check("rdv_unexpected", {28'd0, rdv}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdv_core", {28'd0, rdv}, 32'd1 << e.core);
                check("rdata", rdata, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_wr;
        logic [15:0] saved_cnt;
        id_val = ID;
        do_reset();

        check("t1_wr", {28'd0, wr}, 32'hF);
        check("t1_rdv", {28'd0, rdv}, 32'd0);
        check("t1_sid", {31'd0, sid_addr}, 32'd0);
        check("t1_mism", {31'd0, mism}, 32'd0);
        check("t1_cnt", {16'd0, cnt}, 32'd0);
        check("t1_cnt4", {28'd0, cnt4}, 32'd0);

        req_address = 4'b0100;
        req_read = 4'b0100;
        push(2, TS);
        tick();
        check("t2_wr", {28'd0, wr}, 32'hB);
        check("t2_sid", {31'd0, sid_addr}, 32'd1);
        tick();
        req_read = '0;
        check("t2_rdv", {28'd0, rdv}, 32'h4);
        check("t2_cnt", {16'd0, cnt}, 32'd1);
        check("t2_mism", {31'd0, mism}, 32'd0);
        tick();
        check("t2_rdv_off", {28'd0, rdv}, 32'd0);
        check("t2_hold", rdata, TS);

        do_reset();
        req_address = '0;
        req_read = 4'hF;
        for (int g = 0; g < 5; g++) push(g % 4, ID);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_wr = (k % 2 == 1) ? ~(4'b0001 << (((k - 1) / 2) % 4)) : 4'hF;
            check($sformatf("t3_wr_%0d", k), {28'd0, wr}, {28'd0, exp_wr});
        end
        req_read = '0;
        tick();
        check("t3_sb_empty", sb.size(), 32'd0);

        id_val = 32'h12345678;
        serve(1, 1'b0, 32'h12345678);
        check("t4_mism_set", {31'd0, mism}, 32'd1);
        check("t4_rdv", {28'd0, rdv}, 32'h2);
        id_val = ID;
        serve(1, 1'b0, ID);
        serve(0, 1'b1, TS);
        tick();
        check("t4_mism_sticky", {31'd0, mism}, 32'd1);

        saved_cnt = cnt;
        req_address = '0;
        req_read = 4'b1000;
        tick();
        check("t5_wr3", {28'd0, wr}, 32'h7);
        req_read = '0;
        tick();
        check("t5_no_rdv", {28'd0, rdv}, 32'd0);
        check("t5_cnt_hold", {16'd0, cnt}, {16'd0, saved_cnt});
        req_read = 4'b1001;
        push(0, ID);
        push(3, ID);
        tick();
        check("t5_wr0", {28'd0, wr}, 32'hE);
        tick();
        req_read[0] = 1'b0;
        tick();
        check("t5_wr3b", {28'd0, wr}, 32'h7);
        tick();
        req_read = '0;
        tick();

        req_read = 4'b0100;
        tick();
        check("t6_inread", {28'd0, wr}, 32'hB);
        #1 reset = 1'b1;
        #1;
        check("t6_wr", {28'd0, wr}, 32'hF);
        check("t6_rdv", {28'd0, rdv}, 32'd0);
        check("t6_cnt", {16'd0, cnt}, 32'd0);
        check("t6_mism", {31'd0, mism}, 32'd0);
        check("t6_sid", {31'd0, sid_addr}, 32'd0);
        req_read = '0;
        sb.delete();
        model_cnt = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("t6_no_rdv", {28'd0, rdv}, 32'd0);
        req_address = '0;
        req_read = 4'b0011;
        push(0, ID);
        push(1, ID);
        tick();
        check("t6_wr0", {28'd0, wr}, 32'hE);
        tick();
        req_read[0] = 1'b0;
        tick();
        check("t6_wr1", {28'd0, wr}, 32'hD);
        tick();
        req_read = '0;
        for (int i = 0; i < 20; i++) begin
            serve(i % 4, logic'(i % 2), (i % 2) ? TS : ID);
        end
        tick();
        tick();
        check("t6_cnt22", {16'd0, cnt}, model_cnt);
        check("t6_cnt4_sat", {28'd0, cnt4}, 32'd15);
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Shares the single-word-addressed system-ID slave (address 0 = system ID, address 1 = build timestamp; combinational readdata) between NUM_REQ processor cores in the multicore Ethernet design.
- Each core sees its own Avalon-MM read-only slave port with waitrequest/readdatavalid.
- The block round-robin arbitrates, sequences one registered read at a time and checks returned values against expected constants.
- It raises a sticky mismatch flag and keeps a saturating count of completed reads for boot diagnostics.

Parameters:
- NUM_REQ, 4, number of requesting cores; legal range 1..8.
- EXPECTED_ID, 0, value the slave must return at address 0.
- EXPECTED_TS, 1326413930, value the slave must return at address 1.
- CNT_WIDTH, 16, width of the completed-read counter.

Ports:
- clock, in, 1, single clock for all logic.
- reset, in, 1, asynchronous, active-high reset.
- req_read, in, NUM_REQ, per-core read strobe; held high until accepted.
- req_address, in, NUM_REQ, per-core 1-bit word address (bit i belongs to core i).
- req_waitrequest, out, NUM_REQ, per-core waitrequest.
- req_readdatavalid, out, NUM_REQ, per-core one-cycle data-valid pulse.
- req_readdata, out, 32, shared registered read data, valid for the core whose readdatavalid is high.
- sid_address, out, 1, address driven to the system-ID slave.
- sid_readdata, in, 32, data returned by the system-ID slave (combinational in sid_address).
- id_mismatch, out, 1, sticky: some completed read returned a value other than expected.
- read_count, out, CNT_WIDTH, saturating count of completed reads.

Behaviour:
- Reset (asynchronous, takes effect immediately while reset is high):
  - state = IDLE, grant = 0, last_grant = NUM_REQ-1.
  - sid_address = 0, req_readdata = 0, req_readdatavalid = 0, req_waitrequest = all 1s.
  - id_mismatch = 0, read_count = 0.
  - Any in-flight transaction is discarded with no readdatavalid.
- req_waitrequest is combinational from registered state only. Bit i = 0 iff state == READ and grant == i; all other bits = 1.
- States: IDLE and READ.
- IDLE:
  - If req_read is nonzero, choose the winner by searching from last_grant+1 upward, wrapping modulo NUM_REQ; the first set bit wins.
  - Register grant = winner, last_grant = winner, sid_address = req_address[winner], then go to READ.
  - If req_read is zero, stay in IDLE; all registers hold.
- READ (one cycle; the slave is combinational, so sid_readdata is valid this cycle):
  - If req_read[grant] == 1 (accepted), on the closing edge:
    - req_readdata = sid_readdata.
    - req_readdatavalid[grant] = 1 for exactly one cycle.
    - Compare: if sid_address == 0 and sid_readdata != EXPECTED_ID, or sid_address == 1 and sid_readdata != EXPECTED_TS, set id_mismatch.
    - read_count increments by 1 and saturates at all-ones (no wrap).
  - If req_read[grant] == 0 (illegal Avalon drop), abort: no readdatavalid, no compare, no count; last_grant remains advanced.
  - In both cases, next state = IDLE.
- Timing: read high at edge T in IDLE → waitrequest low during cycle T+1 → readdatavalid high during T+2, with req_readdata valid.
- Throughput: one transaction per 2 cycles. The IDLE cycle that carries the readdatavalid pulse may arbitrate the next request.
- req_readdatavalid deasserts the cycle after its pulse. req_readdata holds its last value until the next completed read.
- Simultaneous requests: only the round-robin winner is served; the others keep waitrequest = 1 and are served in rotation. No core waits more than 2*NUM_REQ cycles.
- Address bits of non-granted cores are ignored. sid_address changes only on an IDLE→READ transition.
- id_mismatch clears only on reset.
- With NUM_REQ = 1, the block degenerates to grant = 0 on every transaction.

Test Plan:
1. Assert and release reset → req_waitrequest = 4'b1111, req_readdatavalid = 0, sid_address = 0, id_mismatch = 0, read_count = 0.
2. Core 2 only, address = 1, read at edge T, slave model correct → req_waitrequest[2] = 0 at T+1; req_readdatavalid = 4'b0100 at T+2 with req_readdata = 1326413930; read_count = 1; id_mismatch = 0.
3. All four cores hold read continuously from T → readdatavalid pulses for cores 0, 1, 2, 3, 0 at T+2, T+4, T+6, T+8, T+10; the other cores' waitrequest stays 1 throughout.
4. Slave model returns 32'h12345678 at address 0; core 1 reads address 0 → req_readdata = 32'h12345678, id_mismatch = 1 from the same edge as readdatavalid and stays 1 through later correct reads.
5. Core 3 granted, then drops read during READ → no readdatavalid, read_count unchanged. A following simultaneous request from cores 0 and 3 is granted to core 0.
6. Reset asserted mid-READ → outputs return to reset values immediately and no readdatavalid is issued. After release, cores 0 and 1 requesting → core 0 wins. With CNT_WIDTH = 4, 20 completed reads → read_count = 15.
